// File: rtl/keypad_pkg.sv
// Shared keypad constants: matrix geometry, key codes, debounce FSM states
// and the frame-to-code helper. The key-code decoder uses the same constants.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 5;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;
    localparam int KEY_W   = 5;

    typedef logic [KEY_W-1:0] key_code_t;

    // Code = row*5 + col + 1; zero means "no event"
    localparam key_code_t KEY_NONE  = 5'd0;
    localparam key_code_t KEY_DOT   = 5'd1;
    localparam key_code_t KEY_ESC   = 5'd2;
    localparam key_code_t KEY_0     = 5'd3;
    localparam key_code_t KEY_ENT   = 5'd4;
    localparam key_code_t KEY_F4    = 5'd5;
    localparam key_code_t KEY_STAR  = 5'd6;
    localparam key_code_t KEY_1     = 5'd7;
    localparam key_code_t KEY_2     = 5'd8;
    localparam key_code_t KEY_3     = 5'd9;
    localparam key_code_t KEY_F3    = 5'd10;
    localparam key_code_t KEY_MINUS = 5'd11;
    localparam key_code_t KEY_4     = 5'd12;
    localparam key_code_t KEY_5     = 5'd13;
    localparam key_code_t KEY_6     = 5'd14;
    localparam key_code_t KEY_F2    = 5'd15;
    localparam key_code_t KEY_PLUS  = 5'd16;
    localparam key_code_t KEY_7     = 5'd17;
    localparam key_code_t KEY_8     = 5'd18;
    localparam key_code_t KEY_9     = 5'd19;
    localparam key_code_t KEY_F1    = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } kp_state_t;

    // Bit i of a frame is key row*KP_COLS+col; exactly one set bit yields its
    // code, anything else (none, multi-key, ghosting) yields KEY_NONE.
    function automatic key_code_t frame_to_code(input logic [KP_KEYS-1:0] bits);
        key_code_t   code;
        int unsigned hits;
        code = KEY_NONE;
        hits = 0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (bits[i]) begin
                hits = hits + 1;
                code = key_code_t'(i + 1);
            end
        end
        return (hits == 1) ? code : KEY_NONE;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Board-side keypad signals plus the key-code output towards the decoder.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KP_ROWS-1:0] o_row_n;
    logic [KP_COLS-1:0] i_col_n;
    key_code_t          o_key_value;
    logic               o_key_held;

    modport master (
        output o_row_n,
        output o_key_value,
        output o_key_held,
        input  i_col_n
    );

    modport slave (
        input  o_row_n,
        input  o_key_value,
        input  o_key_held,
        output i_col_n
    );

endinterface

// File: rtl/keypad_debouncer.sv
// Frame-rate debounce FSM: accepts a press or release only after
// DEBOUNCE_FRAMES consecutive agreeing frames and emits a one-cycle code pulse.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 16
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      frame_done,
    input  key_code_t frame_code,
    output key_code_t key_value,
    output logic      key_held
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    kp_state_t     state, state_nxt;
    key_code_t     cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    key_code_t     key_value_nxt;

    // State, candidate, frame counter and the registered press pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cand      <= KEY_NONE;
            cnt       <= '0;
            key_value <= KEY_NONE;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_value <= key_value_nxt;
        end
    end

    // Next-state logic; only advances on the end-of-frame strobe
    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        key_value_nxt = KEY_NONE;
        if (frame_done) begin
            unique case (state)
                S_IDLE: begin
                    if (frame_code != KEY_NONE) begin
                        cand_nxt  = frame_code;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = S_PRESS_CHK;
                    end
                end
                S_PRESS_CHK: begin
                    if (frame_code == cand) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == CNT_DONE) begin
                            state_nxt     = S_HELD;
                            key_value_nxt = cand;
                        end
                    end else if (frame_code == KEY_NONE) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cand_nxt = frame_code;
                        cnt_nxt  = CNT_ONE;
                    end
                end
                S_HELD: begin
                    // A different key counts as a release: rollover never fires
                    if (frame_code != cand) begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = S_REL_CHK;
                    end
                end
                S_REL_CHK: begin
                    if (frame_code == cand) begin
                        state_nxt = S_HELD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == CNT_DONE) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign key_held = (state == S_HELD) || (state == S_REL_CHK);

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 keypad scanner: walks an active-low row drive, synchronises the column
// returns, builds a full-matrix frame and hands its code to the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100_000,
    parameter int DEBOUNCE_FRAMES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    keypad_scanner_if.master  kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = $clog2(KP_ROWS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(KP_ROWS - 1);

    logic [DW-1:0]      dwell_cnt;
    logic [RW-1:0]      row_idx;
    logic [KP_COLS-1:0] col_sync_p0, col_sync_p1;
    logic [KP_KEYS-1:0] snapshot;
    logic [KP_KEYS-1:0] frame_bits;
    logic               dwell_last;
    logic               frame_done;
    key_code_t          frame_code;

    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign frame_done = dwell_last && (row_idx == ROW_LAST);
    assign kp.o_row_n = ~(KP_ROWS'(1) << row_idx);

    // Two-flop synchroniser; idles high (no key) so reset cannot fake a press
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_sync_p0 <= '1;
            col_sync_p1 <= '1;
        end else begin
            col_sync_p0 <= kp.i_col_n;
            col_sync_p1 <= col_sync_p0;
        end
    end

    // Dwell counter and row index; the row advances when the dwell wraps
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dwell_cnt <= '0;
            row_idx   <= '0;
        end else if (dwell_last) begin
            dwell_cnt <= '0;
            row_idx   <= row_idx + 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Capture the settled columns of the driven row on its last dwell cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snapshot <= '0;
        end else if (dwell_last) begin
            snapshot[row_idx*KP_COLS +: KP_COLS] <= ~col_sync_p1;
        end
    end

    // The last row is still being captured at frame end, so splice it in live
    always_comb begin
        frame_bits = snapshot;
        frame_bits[(KP_ROWS-1)*KP_COLS +: KP_COLS] = ~col_sync_p1;
        frame_code = frame_to_code(frame_bits);
    end

    keypad_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .frame_done (frame_done),
        .frame_code (frame_code),
        .key_value  (kp.o_key_value),
        .key_held   (kp.o_key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (16-cycle frames). Cycle 0 is the first cycle after reset is released.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [KP_KEYS-1:0] keys = '0;
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 pulse_cnt = 0;
    int                 pulse_base = 0;
    key_code_t          last_pulse = KEY_NONE;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven
    always_comb begin
        kp.i_col_n = '1;
        for (int r = 0; r < KP_ROWS; r++) begin
            if (!kp.o_row_n[r]) begin
                kp.i_col_n = kp.i_col_n & ~keys[r*KP_COLS +: KP_COLS];
            end
        end
    end

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (kp.o_key_value != KEY_NONE) begin
            pulse_cnt  = pulse_cnt + 1;
            last_pulse = kp.o_key_value;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pulse_base = pulse_cnt;
    endtask

    initial begin
        // Reset and row walk
        do_reset(2);
        chk("rst_row",  32'(kp.o_row_n), 32'hE);
        chk("rst_val",  32'(kp.o_key_value), 32'd0);
        chk("rst_held", 32'(kp.o_key_held), 32'd0);
        run_to(4);
        chk("row1", 32'(kp.o_row_n), 32'hD);
        run_to(8);
        chk("row2", 32'(kp.o_row_n), 32'hB);
        run_to(12);
        chk("row3", 32'(kp.o_row_n), 32'h7);
        run_to(16);
        chk("row0_wrap", 32'(kp.o_row_n), 32'hE);

        // Clean press of digit 6 (row 2, col 3) for 10 frames
        do_reset(2);
        keys = '0;
        keys[13] = 1'b1;
        run_to(47);
        chk("clean_pre_val",  32'(kp.o_key_value), 32'd0);
        chk("clean_pre_held", 32'(kp.o_key_held), 32'd0);
        run_to(48);
        chk("clean_pulse", 32'(kp.o_key_value), 32'd14);
        chk("clean_held",  32'(kp.o_key_held), 32'd1);
        run_to(49);
        chk("clean_post_val", 32'(kp.o_key_value), 32'd0);
        run_to(160);
        keys = '0;
        run_to(207);
        chk("clean_rel_held1", 32'(kp.o_key_held), 32'd1);
        run_to(208);
        chk("clean_rel_held0", 32'(kp.o_key_held), 32'd0);
        chk("clean_npulse", 32'(pulse_cnt - pulse_base), 32'd1);
        chk("clean_last",   32'(last_pulse), 32'd14);

        // Bounce: F1 two frames on, one frame off, three times
        do_reset(2);
        keys = '0;
        keys[19] = 1'b1;
        run_to(32);  keys = '0;
        run_to(48);  keys[19] = 1'b1;
        run_to(80);  keys = '0;
        run_to(96);  keys[19] = 1'b1;
        run_to(128); keys = '0;
        run_to(176);
        chk("bounce_npulse", 32'(pulse_cnt - pulse_base), 32'd0);
        chk("bounce_held",   32'(kp.o_key_held), 32'd0);

        // Multi-key: codes 7 and 8 together, then only 7
        do_reset(2);
        keys = '0;
        keys[6] = 1'b1;
        keys[7] = 1'b1;
        run_to(96);
        chk("multi_npulse0", 32'(pulse_cnt - pulse_base), 32'd0);
        chk("multi_held0",   32'(kp.o_key_held), 32'd0);
        keys[7] = 1'b0;
        run_to(143);
        chk("multi_pre_val", 32'(kp.o_key_value), 32'd0);
        run_to(144);
        chk("multi_pulse", 32'(kp.o_key_value), 32'd7);
        chk("multi_held",  32'(kp.o_key_held), 32'd1);
        run_to(160);
        chk("multi_npulse1", 32'(pulse_cnt - pulse_base), 32'd1);
        keys = '0;

        // Rollover ENT -> ESC without a gap, then a fresh ESC press
        do_reset(2);
        keys = '0;
        keys[3] = 1'b1;
        run_to(48);
        chk("roll_ent", 32'(kp.o_key_value), 32'd4);
        run_to(64);
        keys = '0;
        keys[1] = 1'b1;
        run_to(111);
        chk("roll_held1", 32'(kp.o_key_held), 32'd1);
        run_to(112);
        chk("roll_held0", 32'(kp.o_key_held), 32'd0);
        chk("roll_npulse", 32'(pulse_cnt - pulse_base), 32'd1);
        keys = '0;
        run_to(128);
        keys[1] = 1'b1;
        run_to(175);
        chk("roll_esc_pre", 32'(kp.o_key_value), 32'd0);
        run_to(176);
        chk("roll_esc", 32'(kp.o_key_value), 32'd2);
        run_to(192);
        chk("roll_npulse2", 32'(pulse_cnt - pulse_base), 32'd2);
        chk("roll_last",    32'(last_pulse), 32'd2);
        keys = '0;

        // Reset while key 3 is held: re-debounced from idle
        do_reset(2);
        keys = '0;
        keys[2] = 1'b1;
        run_to(48);
        chk("midrst_first", 32'(kp.o_key_value), 32'd3);
        run_to(70);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pulse_base = pulse_cnt;
        chk("midrst_row",  32'(kp.o_row_n), 32'hE);
        chk("midrst_val",  32'(kp.o_key_value), 32'd0);
        chk("midrst_held", 32'(kp.o_key_held), 32'd0);
        run_to(47);
        chk("midrst_pre_val",  32'(kp.o_key_value), 32'd0);
        chk("midrst_pre_held", 32'(kp.o_key_held), 32'd0);
        run_to(48);
        chk("midrst_pulse", 32'(kp.o_key_value), 32'd3);
        chk("midrst_held1", 32'(kp.o_key_held), 32'd1);
        run_to(64);
        chk("midrst_npulse", 32'(pulse_cnt - pulse_base), 32'd1);
        keys = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
